// File: rtl/lms_weight_update_if.sv
// Sample/weight bus between the LMS adaptation stage and its FIR/upstream neighbours.
// The slave side is the adaptation stage; the master side drives samples and consumes weights.
interface lms_weight_update_if #(
    parameter int N          = 10,
    parameter int DATA_WIDTH = 16
);
    logic                                start;
    logic                                adapt_en;
    logic signed [DATA_WIDTH-1:0]        x_in;
    logic signed [DATA_WIDTH-1:0]        d_in;
    logic signed [DATA_WIDTH-1:0]        y_in;
    logic        [N-1:0][DATA_WIDTH-1:0] weights;
    logic signed [DATA_WIDTH-1:0]        e_out;
    logic                                busy;
    logic                                done;

    modport slave (
        input  start, adapt_en, x_in, d_in, y_in,
        output weights, e_out, busy, done
    );

    modport master (
        output start, adapt_en, x_in, d_in, y_in,
        input  weights, e_out, busy, done
    );
endinterface

// File: rtl/lms_weight_update.sv
// LMS adaptation stage: latches e = d - y per sample, then serially updates one tap
// per cycle with w[i] += ((e*x[i]) >>> (DW-1)) >>> MU_SHIFT, all Q1.15 saturating.
module lms_weight_update #(
    parameter int N          = 10,
    parameter int DATA_WIDTH = 16,
    parameter int MU_SHIFT   = 4
) (
    input  logic               clk,
    input  logic               rst,
    lms_weight_update_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic signed [PW-1:0] S_MAX = PW'(2 ** (DW - 1) - 1);
    localparam logic signed [PW-1:0] S_MIN = -S_MAX - PW'(1);

    typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

    state_t                        state;
    logic     [CW-1:0]             cntr;
    logic                          adapt_q;
    logic     [N-1:0][DW-1:0]      weights_q;
    logic     [N-1:0][DW-1:0]      x_dly;
    logic signed [DW-1:0]          e_q;
    logic                          busy_q;
    logic                          done_q;

    logic signed [DW-1:0]          e_new;
    logic signed [DW-1:0]          w_new;
    logic signed [PW-1:0]          prod;
    logic signed [PW-1:0]          delta;
    logic signed [PW-1:0]          sum;

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [PW-1:0] v);
        if (v > S_MAX)
            return S_MAX[DW-1:0];
        else if (v < S_MIN)
            return S_MIN[DW-1:0];
        else
            return v[DW-1:0];
    endfunction

    // Both operands are widened before the arithmetic so nothing wraps ahead of saturation.
    always_comb begin
        e_new = sat_dw(PW'(bus.d_in) - PW'(bus.y_in));
        prod  = PW'(e_q) * PW'($signed(x_dly[cntr]));
        delta = (prod >>> (DW - 1)) >>> MU_SHIFT;
        sum   = PW'($signed(weights_q[cntr])) + delta;
        w_new = sat_dw(sum);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cntr      <= '0;
            adapt_q   <= 1'b0;
            weights_q <= '0;
            x_dly     <= '0;
            e_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        x_dly[0] <= bus.x_in;
                        for (int unsigned i = 1; i < N; i++)
                            x_dly[i] <= x_dly[i-1];
                        e_q     <= e_new;
                        adapt_q <= bus.adapt_en;
                        cntr    <= '0;
                        busy_q  <= 1'b1;
                        state   <= UPDATE;
                    end
                end
                UPDATE: begin
                    if (adapt_q)
                        weights_q[cntr] <= w_new;
                    if (cntr == LAST) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cntr <= cntr + CW'(1);
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.weights = weights_q;
    assign bus.e_out   = e_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_lms_weight_update.sv
// Randomized bench for lms_weight_update (N=4, MU_SHIFT=4) against an array-based
// reference model of the delay line, error and per-tap saturating weight updates.
module tb_lms_weight_update;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MU = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    // reference model state
    longint mw[N];
    longint mx[N];
    longint me;

    lms_weight_update_if #(.N(N), .DATA_WIDTH(DW)) bus ();

    lms_weight_update #(.N(N), .DATA_WIDTH(DW), .MU_SHIFT(MU)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint clamp(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int rnd_s16();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mw[i] = 0;
            mx[i] = 0;
        end
        me = 0;
    endtask

    task automatic model_step(input int x, input int d, input int y, input bit adapt);
        for (int i = N - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = x;
        me = clamp(longint'(d) - longint'(y));
        if (adapt)
            for (int i = 0; i < N; i++)
                mw[i] = clamp(mw[i] + (((me * mx[i]) >>> (DW - 1)) >>> MU));
    endtask

    task automatic randomize_inputs();
        bus.x_in     = 16'(rnd_s16());
        bus.d_in     = 16'(rnd_s16());
        bus.y_in     = 16'(rnd_s16());
        bus.adapt_en = 1'($urandom_range(1));
    endtask

    // Called at a falling edge; drives start there and checks every cycle through N+2.
    task automatic run_sample(input int x, input int d, input int y, input bit adapt, input bit inject);
        longint ow[N];
        for (int i = 0; i < N; i++) ow[i] = mw[i];
        bus.start    = 1'b1;
        bus.x_in     = 16'(x);
        bus.d_in     = 16'(d);
        bus.y_in     = 16'(y);
        bus.adapt_en = adapt;
        model_step(x, d, y, adapt);
        @(negedge clk);
        bus.start = 1'b0;
        randomize_inputs();
        for (int k = 1; k <= N + 1; k++) begin
            check($sformatf("busy_c%0d", k), longint'(bus.busy), 1);
            check($sformatf("done_c%0d", k), longint'(bus.done), (k == N + 1) ? 1 : 0);
            check("e_out", longint'($signed(bus.e_out)), me);
            for (int i = 0; i < N; i++)
                check($sformatf("w%0d_c%0d", i, k), longint'($signed(bus.weights[i])),
                      (i + 2 <= k) ? mw[i] : ow[i]);
            if (inject && k == 2) begin
                bus.start = 1'b1;
                randomize_inputs();
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        check("busy_idle", longint'(bus.busy), 0);
        check("done_idle", longint'(bus.done), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.start = 1'($urandom_range(1));
        randomize_inputs();
        @(negedge clk);
        bus.start = 1'($urandom_range(1));
        randomize_inputs();
        @(negedge clk);
        for (int i = 0; i < N; i++)
            check($sformatf("rst_w%0d", i), longint'($signed(bus.weights[i])), 0);
        check("rst_e_out", longint'($signed(bus.e_out)), 0);
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_done", longint'(bus.done), 0);
        rst = 1'b0;
        bus.start = 1'b0;
        model_clear();
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        randomize_inputs();
        model_clear();
        @(negedge clk);

        // reset, then a single directed update
        do_reset();
        run_sample(16384, 8192, 0, 1'b1, 1'b0);
        check("t2_e_out", longint'($signed(bus.e_out)), 8192);
        check("t2_w0", longint'($signed(bus.weights[0])), 256);
        check("t2_w1", longint'($signed(bus.weights[1])), 0);

        // error saturation in both directions
        run_sample(rnd_s16(), 32767, -32768, 1'b1, 1'b0);
        check("esat_pos", longint'($signed(bus.e_out)), 32767);
        run_sample(rnd_s16(), -32768, 32767, 1'b1, 1'b0);
        check("esat_neg", longint'($signed(bus.e_out)), -32768);

        // start while busy is ignored; adapt_en=0 freezes weights
        run_sample(rnd_s16(), rnd_s16(), rnd_s16(), 1'b1, 1'b1);
        run_sample(rnd_s16(), rnd_s16(), rnd_s16(), 1'b0, 1'b1);
        run_sample(rnd_s16() / 4, rnd_s16() / 4, rnd_s16() / 4, 1'b1, 1'b0);

        // reset in cycle 2 of an update
        bus.start = 1'b1;
        randomize_inputs();
        bus.adapt_en = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < N; i++)
            check($sformatf("mid_rst_w%0d", i), longint'($signed(bus.weights[i])), 0);
        check("mid_rst_busy", longint'(bus.busy), 0);
        check("mid_rst_done", longint'(bus.done), 0);
        for (int k = 0; k < N + 1; k++) begin
            @(negedge clk);
            check("mid_rst_no_done", longint'(bus.done), 0);
            check("mid_rst_no_busy", longint'(bus.busy), 0);
        end
        run_sample(16384, 8192, 0, 1'b1, 1'b0);
        check("t6_w0", longint'($signed(bus.weights[0])), 256);

        // weight saturation on tap 0
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            run_sample(32767, 32767, 0, 1'b1, 1'b0);
            if (n == 16) check("wsat_16", longint'($signed(bus.weights[0])), 32752);
            if (n >= 17) check($sformatf("wsat_%0d", n), longint'($signed(bus.weights[0])), 32767);
        end

        // randomized traffic, mixing small and full-scale values
        do_reset();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(1) == 1)
                run_sample(rnd_s16(), rnd_s16(), rnd_s16(),
                           ($urandom_range(3) != 0), 1'($urandom_range(1)));
            else
                run_sample(rnd_s16() / 8, rnd_s16() / 8, rnd_s16() / 8,
                           ($urandom_range(3) != 0), 1'($urandom_range(1)));
            if ($urandom_range(3) == 0) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
